// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between ALU writeback and load
// return, with round-robin arbitration and a per-register load scoreboard.
module rf_write_arbiter #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  // ALU writeback requester
  input  logic          alu_valid,
  input  logic [D-1:0]  alu_waddr,
  input  logic [W-1:0]  alu_data,
  output logic          alu_ready,
  // Load-return requester
  input  logic          ld_valid,
  input  logic [D-1:0]  ld_waddr,
  input  logic [W-1:0]  ld_data,
  output logic          ld_ready,
  // Load issue and operand hazard lookup
  input  logic          issue_ld,
  input  logic [D-1:0]  issue_ld_addr,
  input  logic [D-1:0]  raddrA,
  input  logic [D-1:0]  raddrB,
  output logic          hazardA,
  output logic          hazardB,
  // Registered write command toward the register file
  output logic          rf_write_en,
  output logic [D-1:0]  rf_waddr,
  output logic [W-1:0]  rf_data_in,
  output logic          rf_src,
  // Status
  output logic          busy_any,
  output logic [CW-1:0] contention_cnt
);

  localparam int NREG = 2**D;
  // The top register reads as zero, so writes to it are swallowed.
  localparam logic [D-1:0]  ZERO_REG = '1;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  logic [NREG-1:0] busy_q, busy_d;
  src_e            last_grant_q, last_grant_d;
  logic            rf_write_en_q, rf_write_en_d;
  logic [D-1:0]    rf_waddr_q, rf_waddr_d;
  logic [W-1:0]    rf_data_q, rf_data_d;
  src_e            rf_src_q, rf_src_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic alu_elig, ld_elig;
  logic grant_alu, grant_ld;
  logic stall;

  // Grant: a lone eligible requester wins; on a tie the one not served last wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    alu_elig  = alu_valid & ~busy_q[alu_waddr];
    ld_elig   = ld_valid;
    if (!reset) begin
      if (alu_elig && (!ld_elig || last_grant_q == SRC_LD)) begin
        grant_alu = 1'b1;
      end else if (ld_elig) begin
        grant_ld = 1'b1;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

  // Scoreboard: the set is applied after the clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (grant_ld) begin
      busy_d[ld_waddr] = 1'b0;
    end
    if (issue_ld && issue_ld_addr != ZERO_REG) begin
      busy_d[issue_ld_addr] = 1'b1;
    end
  end

  // Write command: address, data and source hold when nothing is granted.
  always_comb begin
    rf_write_en_d = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_data_d     = rf_data_q;
    rf_src_d      = rf_src_q;
    last_grant_d  = last_grant_q;
    if (grant_alu) begin
      rf_write_en_d = (alu_waddr != ZERO_REG);
      rf_waddr_d    = alu_waddr;
      rf_data_d     = alu_data;
      rf_src_d      = SRC_ALU;
      last_grant_d  = SRC_ALU;
    end else if (grant_ld) begin
      rf_write_en_d = (ld_waddr != ZERO_REG);
      rf_waddr_d    = ld_waddr;
      rf_data_d     = ld_data;
      rf_src_d      = SRC_LD;
      last_grant_d  = SRC_LD;
    end
  end

  // Contention: any valid requester left waiting this cycle.
  always_comb begin
    stall = (alu_valid & ~grant_alu) | (ld_valid & ~grant_ld);
    cnt_d = cnt_q;
    if (stall && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      // NOTE: the scoreboard is a small flop vector, not RAM, so clearing it
      // in reset is cheap and required to drop in-flight load tracking.
      busy_q        <= '0;
      last_grant_q  <= SRC_LD;
      rf_write_en_q <= 1'b0;
      rf_waddr_q    <= '0;
      rf_data_q     <= '0;
      rf_src_q      <= SRC_ALU;
      cnt_q         <= '0;
    end else begin
      busy_q        <= busy_d;
      last_grant_q  <= last_grant_d;
      rf_write_en_q <= rf_write_en_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_data_q     <= rf_data_d;
      rf_src_q      <= rf_src_d;
      cnt_q         <= cnt_d;
    end
  end

  assign hazardA        = busy_q[raddrA];
  assign hazardB        = busy_q[raddrB];
  assign rf_write_en    = rf_write_en_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_data_in     = rf_data_q;
  assign rf_src         = rf_src_q;
  assign busy_any       = |busy_q;
  assign contention_cnt = cnt_q;

  grant_onehot: assert property (@(posedge clk) disable iff (reset)
    !(grant_alu && grant_ld));

endmodule
